// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider:
//   - DIV_WIDTH_DEFAULT : default operand/result width
//   - div_state_e       : controller states (IDLE, CALC, FIX, DONE)
//   - div_cnt_width()   : iteration counter width for a given operand width
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // The counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_sub_unit.sv
// -----------------------------------------------------------------------------
// div_sub_unit
// Trial subtractor for one restoring-division step.
//   minuend     in  [WIDTH-1:0]  shifted partial remainder
//   subtrahend  in  [WIDTH-1:0]  zero-extended divisor magnitude
//   difference  out [WIDTH-1:0]  minuend - subtrahend (mod 2^WIDTH)
//   borrow      out              1 when subtrahend > minuend
// -----------------------------------------------------------------------------
module div_sub_unit #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH-1:0] difference,
    output logic             borrow
);

    // One extra bit on the left catches the borrow out of the MSB.
    logic [WIDTH:0] full_diff;

    assign full_diff  = {1'b0, minuend} - {1'b0, subtrahend};
    assign difference = full_diff[WIDTH-1:0];
    assign borrow     = full_diff[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider, one quotient bit per clock, with optional
// two's-complement (truncating) mode.
//
// Parameters
//   WIDTH      operand/result width (4..64)
//   SIGNED_EN  1 = Signed_mode honoured, 0 = always unsigned
//
// Ports
//   clk            in   clock, rising edge
//   Reset_n        in   asynchronous active-low reset
//   Start          in   request pulse, sampled only in IDLE
//   Signed_mode    in   1 = signed operands (sampled with Start)
//   Dividend_in    in   [WIDTH-1:0] dividend (sampled with Start)
//   Divisor_in     in   [WIDTH-1:0] divisor  (sampled with Start)
//   Busy           out  high while CALC/FIX are running
//   Done           out  one-cycle pulse, results valid
//   Quotient_out   out  [WIDTH-1:0] quotient, held until next result
//   Remainder_out  out  [WIDTH-1:0] remainder, same sign as dividend
//   Div_by_zero    out  flags a zero divisor; cleared by next accepted Start
//
// Latency from the accepting edge to the edge that samples Done is WIDTH+2
// for a nonzero divisor and 1 for a zero divisor.
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = DIV_WIDTH_DEFAULT,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Signed_mode,
    input  logic [WIDTH-1:0] Dividend_in,
    input  logic [WIDTH-1:0] Divisor_in,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient_out,
    output logic [WIDTH-1:0] Remainder_out,
    output logic             Div_by_zero
);

    localparam int CNT_W = div_cnt_width(WIDTH);
    // {partial remainder (WIDTH+1 bits), quotient/dividend (WIDTH bits)}
    localparam int ACC_W = 2 * WIDTH + 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    div_state_e        state_reg;
    div_state_e        state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [WIDTH-1:0]  divisor_reg;
    logic              q_neg_reg;
    logic              r_neg_reg;
    logic [WIDTH-1:0]  quotient_reg;
    logic [WIDTH-1:0]  remainder_reg;
    logic              dbz_reg;

    // -------------------------------------------------------------------------
    // Operand conditioning at acceptance
    // -------------------------------------------------------------------------
    logic              signed_eff;
    logic              dividend_neg;
    logic              divisor_neg;
    logic [WIDTH-1:0]  dividend_mag;
    logic [WIDTH-1:0]  divisor_mag;
    logic              divisor_zero;
    logic              accept;

    assign signed_eff   = SIGNED_EN & Signed_mode;
    assign dividend_neg = signed_eff & Dividend_in[WIDTH-1];
    assign divisor_neg  = signed_eff & Divisor_in[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which read as unsigned is exactly the
    // magnitude 2^(WIDTH-1); the overflow case therefore needs no special path.
    assign dividend_mag = dividend_neg ? (~Dividend_in + 1'b1) : Dividend_in;
    assign divisor_mag  = divisor_neg  ? (~Divisor_in  + 1'b1) : Divisor_in;
    assign divisor_zero = (Divisor_in == '0);
    assign accept       = (state_reg == IDLE) && Start;

    // -------------------------------------------------------------------------
    // One restoring shift-subtract step
    // -------------------------------------------------------------------------
    logic [ACC_W-1:0]  acc_shift;
    logic [WIDTH:0]    trial_diff;
    logic              trial_borrow;
    logic [ACC_W-1:0]  acc_iter;
    logic [WIDTH-1:0]  quo_raw;
    logic [WIDTH-1:0]  rem_raw;
    logic              unused_acc_msb;

    // The partial remainder is always below the divisor after a step, so the
    // accumulator MSB is zero going into every shift and can be dropped.
    assign acc_shift      = {acc_reg[ACC_W-2:0], 1'b0};
    assign unused_acc_msb = acc_reg[ACC_W-1];

    div_sub_unit #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .minuend    (acc_shift[ACC_W-1:WIDTH]),
        .subtrahend ({1'b0, divisor_reg}),
        .difference (trial_diff),
        .borrow     (trial_borrow)
    );

    // No borrow: keep the difference and shift in a 1. Borrow: the shifted
    // value is the restored remainder and its LSB is already 0.
    assign acc_iter = trial_borrow ? acc_shift
                                   : {trial_diff, acc_shift[WIDTH-1:1], 1'b1};

    assign quo_raw = acc_reg[WIDTH-1:0];
    assign rem_raw = acc_reg[2*WIDTH-1:WIDTH];

    // -------------------------------------------------------------------------
    // Controller: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Controller: next state and status outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                Busy = 1'b1;
                // This edge performs the last iteration and takes the count to 0.
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                Busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_reg       <= '0;
            acc_reg       <= '0;
            divisor_reg   <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        dbz_reg <= divisor_zero;
                        if (divisor_zero) begin
                            quotient_reg  <= '1;
                            remainder_reg <= Dividend_in;
                        end else begin
                            acc_reg     <= {{(WIDTH + 1){1'b0}}, dividend_mag};
                            divisor_reg <= divisor_mag;
                            cnt_reg     <= CNT_W'(WIDTH);
                            q_neg_reg   <= dividend_neg ^ divisor_neg;
                            r_neg_reg   <= dividend_neg;
                        end
                    end
                end
                CALC: begin
                    acc_reg <= acc_iter;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
                FIX: begin
                    quotient_reg  <= q_neg_reg ? (~quo_raw + 1'b1) : quo_raw;
                    remainder_reg <= r_neg_reg ? (~rem_raw + 1'b1) : rem_raw;
                end
                default: begin
                end
            endcase
        end
    end

    assign Quotient_out  = quotient_reg;
    assign Remainder_out = remainder_reg;
    assign Div_by_zero   = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Drives a 32-bit and an 8-bit seq_divider. Each accepted request pushes its
// expected result (from a behavioural model using native integer division)
// onto a per-instance queue; a monitor pops and compares on every Done.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        s32_start, s32_sm;
    logic [31:0] s32_a, s32_b;
    logic        s32_busy, s32_done, s32_dbz;
    logic [31:0] s32_q, s32_r;

    logic        s8_start, s8_sm;
    logic [7:0]  s8_a, s8_b;
    logic        s8_busy, s8_done, s8_dbz;
    logic [7:0]  s8_q, s8_r;

    seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .clk           (clk),
        .Reset_n       (rst_n),
        .Start         (s32_start),
        .Signed_mode   (s32_sm),
        .Dividend_in   (s32_a),
        .Divisor_in    (s32_b),
        .Busy          (s32_busy),
        .Done          (s32_done),
        .Quotient_out  (s32_q),
        .Remainder_out (s32_r),
        .Div_by_zero   (s32_dbz)
    );

    seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk           (clk),
        .Reset_n       (rst_n),
        .Start         (s8_start),
        .Signed_mode   (s8_sm),
        .Dividend_in   (s8_a),
        .Divisor_in    (s8_b),
        .Busy          (s8_busy),
        .Done          (s8_done),
        .Quotient_out  (s8_q),
        .Remainder_out (s8_r),
        .Div_by_zero   (s8_dbz)
    );

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dbz;
        int          acc;
    } exp_t;

    exp_t sb32[$];
    exp_t sb8[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Truncating division reference; zero divisor gives all-ones / dividend.
    function automatic exp_t model(input int w, input bit sm,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [63:0] mask;
        longint      sa;
        longint      sbv;
        mask  = (64'd1 << w) - 64'd1;
        e.dbz = (b == 64'd0);
        e.acc = 0;
        if (b == 64'd0) begin
            e.q = mask;
            e.r = a;
        end else if (sm) begin
            sa  = a[w-1] ? longint'(a | ~mask) : longint'(a);
            sbv = b[w-1] ? longint'(b | ~mask) : longint'(b);
            e.q = 64'(sa / sbv) & mask;
            e.r = 64'(sa % sbv) & mask;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // ---------------------------------------------------------------- monitors
    always @(negedge clk) begin : mon32
        exp_t e;
        if (rst_n && s32_done) begin
            if (sb32.size() == 0) begin
                check("w32_unexpected_done", 64'(s32_done), 64'd0);
            end else begin
                e = sb32.pop_front();
                check("w32_quotient",  64'(s32_q),   e.q);
                check("w32_remainder", 64'(s32_r),   e.r);
                check("w32_dbz",       64'(s32_dbz), 64'(e.dbz));
                check("w32_busy_at_done", 64'(s32_busy), 64'd0);
                check("w32_latency", 64'(cyc - e.acc + 1), e.dbz ? 64'd1 : 64'd34);
                $display("w32 done: q=0x%08h r=0x%08h dbz=%0d", s32_q, s32_r, s32_dbz);
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n && s8_done) begin
            if (sb8.size() == 0) begin
                check("w8_unexpected_done", 64'(s8_done), 64'd0);
            end else begin
                e = sb8.pop_front();
                check("w8_quotient",  64'(s8_q),   e.q);
                check("w8_remainder", 64'(s8_r),   e.r);
                check("w8_dbz",       64'(s8_dbz), 64'(e.dbz));
                check("w8_latency", 64'(cyc - e.acc + 1), e.dbz ? 64'd1 : 64'd10);
                $display("w8  done: q=0x%02h r=0x%02h dbz=%0d", s8_q, s8_r, s8_dbz);
            end
        end
    end

    // ------------------------------------------------------------------ drivers
    // Call away from the rising edge with the DUT idle.
    task automatic issue32(input bit sm, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        s32_sm = sm; s32_a = a; s32_b = b; s32_start = 1'b1;
        @(posedge clk); #1;
        s32_start = 1'b0;
        e     = model(32, sm, 64'(a), 64'(b));
        e.acc = cyc;
        sb32.push_back(e);
        check("w32_busy_after_accept", 64'(s32_busy), 64'(b != 32'd0));
        check("w32_dbz_after_accept",  64'(s32_dbz),  64'(b == 32'd0));
        // Operands wander while the operation runs; the result must not care.
        s32_a  = $urandom;
        s32_b  = $urandom;
        s32_sm = ~sm;
    endtask

    task automatic issue8(input bit sm, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        s8_sm = sm; s8_a = a; s8_b = b; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        e     = model(8, sm, 64'(a), 64'(b));
        e.acc = cyc;
        sb8.push_back(e);
        check("w8_busy_after_accept", 64'(s8_busy), 64'(b != 8'd0));
        s8_a  = 8'($urandom);
        s8_b  = 8'($urandom);
        s8_sm = ~sm;
    endtask

    task automatic wait_idle32();
        int n;
        n = 0;
        while (sb32.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb32.size() != 0) begin
            check("w32_done_timeout", 64'd1, 64'd0);
            sb32.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_idle8();
        int n;
        n = 0;
        while (sb8.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb8.size() != 0) begin
            check("w8_done_timeout", 64'd1, 64'd0);
            sb8.delete();
        end
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- stimulus
    localparam int N32 = 10;
    bit          t32_sm [N32] = '{0, 1, 0, 1, 1, 0, 0, 1, 1, 0};
    logic [31:0] t32_a  [N32] = '{32'd100, 32'hFFFFFFF9, 32'h1234, 32'd7, 32'hFFFFFF9C,
                                  32'hFFFFFFFF, 32'd5, 32'h80000000, 32'hFFFFFFFB, 32'd0};
    logic [31:0] t32_b  [N32] = '{32'd7, 32'd2, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFF9,
                                  32'd1, 32'd10, 32'hFFFFFFFF, 32'd0, 32'd3};

    localparam int N8 = 6;
    bit          t8_sm [N8] = '{1, 0, 1, 0, 1, 1};
    logic [7:0]  t8_a  [N8] = '{8'h80, 8'hFF, 8'h85, 8'hC8, 8'h7F, 8'h2A};
    logic [7:0]  t8_b  [N8] = '{8'hFF, 8'h01, 8'h07, 8'h0D, 8'h80, 8'h00};

    initial begin : main
        int n;
        rst_n = 1'b0;
        s32_start = 1'b0; s32_sm = 1'b0; s32_a = '0; s32_b = '0;
        s8_start  = 1'b0; s8_sm  = 1'b0; s8_a  = '0; s8_b  = '0;
        #12;
        check("rst_w32_q",    64'(s32_q),    64'd0);
        check("rst_w32_r",    64'(s32_r),    64'd0);
        check("rst_w32_dbz",  64'(s32_dbz),  64'd0);
        check("rst_w32_busy", 64'(s32_busy), 64'd0);
        check("rst_w32_done", 64'(s32_done), 64'd0);
        check("rst_w8_q",     64'(s8_q),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First request lands on the first rising edge after reset release.
        for (int i = 0; i < N32; i++) begin
            issue32(t32_sm[i], t32_a[i], t32_b[i]);
            wait_idle32();
        end
        for (int i = 0; i < 6; i++) begin
            issue32(1'($urandom), $urandom, $urandom_range(1, 32'hFFFF));
            wait_idle32();
        end
        for (int i = 0; i < N8; i++) begin
            issue8(t8_sm[i], t8_a[i], t8_b[i]);
            wait_idle8();
        end

        // Start while busy and in the Done cycle: both ignored.
        issue32(1'b0, 32'd1000, 32'd3);
        repeat (3) @(negedge clk);
        s32_start = 1'b1; s32_a = 32'd50; s32_b = 32'd5;
        @(posedge clk); #1;
        s32_start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s32_done && n < 100);
        check("w32_done_seen", 64'(s32_done), 64'd1);
        s32_start = 1'b1; s32_a = 32'd9; s32_b = 32'd2;
        @(posedge clk); #1;
        s32_start = 1'b0;
        check("w32_start_in_done_ignored", 64'(s32_busy), 64'd0);
        repeat (5) @(negedge clk);
        check("w32_still_idle", 64'(s32_busy), 64'd0);
        check("w32_q_held", 64'(s32_q), 64'd333);
        check("w32_r_held", 64'(s32_r), 64'd1);

        // Asynchronous reset in the middle of CALC aborts the operation.
        issue32(1'b0, 32'hFFFF0000, 32'd3);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_w32_q",    64'(s32_q),    64'd0);
        check("midrst_w32_r",    64'(s32_r),    64'd0);
        check("midrst_w32_busy", 64'(s32_busy), 64'd0);
        check("midrst_w32_done", 64'(s32_done), 64'd0);
        sb32.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue32(1'b0, 32'd20, 32'd6);
        wait_idle32();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
